bcd2bin_seq: RTL
================

# bcd2bin_seq

Sequential BCD-to-binary converter (reverse double-dabble) for the score and timer paths. It turns a 3-digit packed BCD value, such as keypad or setting entry held in BCD, back into an 8-bit binary number for the game arithmetic. One bit is resolved per clock, using a start/ready/valid handshake. It also flags non-decimal digits and values above 255.

## Interface
- DIGITS, 3, number of packed BCD digits (4 bits each)
- BIN_W, 8, binary result width; also the number of shift iterations
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request conversion; sampled only while ready=1
- bcd  input  4*DIGITS  packed BCD operand, digit 0 in bits [3:0]; sampled with start
- ready  output  1  high in IDLE; start accepted only then
- valid  output  1  one-cycle pulse; bin/err hold the result that cycle and after
- bin  output  BIN_W  converted value; held until next accepted start
- err  output  1  1 = invalid digit (>9) or value ≥ 2^BIN_W; bin forced to 0

## Operation
- Reset (async, rst=1): state=IDLE, ready=1, valid=0, bin=0, err=0, shift register and counter cleared. Reset mid-conversion aborts it; no valid is produced.
- IDLE: ready=1. On start=1, check every digit of bcd.
  - Any digit >9: go to DONE with err=1, bin=0.
  - Otherwise: load shift register {bcd, BIN_W'b0}, clear counter, go to SHIFT.
- SHIFT: ready=0, one iteration per cycle.
  - Shift the whole {bcd_part, bin_part} register right by 1.
  - Then, in each BCD digit of the shifted register, any value ≥8 is reduced by 3.
  - Counter counts 0..BIN_W-1. After iteration BIN_W-1 go to DONE.
- DONE: valid=1 for exactly one cycle, ready=0, then IDLE.
  - bin = bin_part.
  - err = 1 if residual bcd_part ≠ 0 (overflow, value ≥ 2^BIN_W); in that case bin=0.
- bin and err are registered. They update only on entry to DONE and are stable until the next DONE.
- start while ready=0 is ignored; no queueing. start held high re-triggers on the first IDLE cycle after DONE.
- Changes to bcd after acceptance have no effect on the conversion in flight.
- Arithmetic:
  - The per-digit adjust is a 4-bit compare (≥8) and subtract 3, applied to all DIGITS in parallel.
  - The residual is exactly floor(value/2^BIN_W), so the overflow test is exact.

## Timing
- Start accepted at edge k → SHIFT from k through k+BIN_W-1 (BIN_W iterations) → DONE at edge k+BIN_W, valid high for that cycle → IDLE at k+BIN_W+1.
- Defaults: valid high 8 cycles after the accepting edge. ready low for 9 cycles.
- Next start can be accepted at edge k+BIN_W+1 (throughput one conversion per BIN_W+1 cycles).
- Invalid-digit path: DONE at edge k, valid in the cycle after acceptance, ready back at k+1.
- No combinational path from start/bcd to any output.

## Structure
- Shared header `bcd_defs.vh` holds:
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE
  - BCD digit width (4)
  - adjust threshold (8) and adjust constant (3)
- Sub-module `bcd_digit_adj`: 4-bit in → 4-bit out, subtracts 3 when the input is ≥8. Instantiated DIGITS times via generate.
- Top holds the FSM, iteration counter ($clog2(BIN_W) bits), shift register (4*DIGITS+BIN_W bits) and the output registers.

## Test plan
- Reset, then bcd=12'h123 with a 1-cycle start → valid exactly 8 cycles after the accepting edge, bin=8'd123 (0x7B), err=0; ready low for 9 cycles.
- bcd=12'h255 → bin=255, err=0. Also bcd=12'h000 → bin=0, err=0.
- bcd=12'h256 → after 8 cycles valid=1, err=1, bin=0. Also 12'h999 → err=1.
- bcd=12'h1A3 (invalid digit) → valid on the next cycle, err=1, bin=0, ready=1 one cycle later.
- Convert 12'h042, pulse start with 12'h200 during SHIFT → the second start is ignored, result bin=42. Then start held high for 20 cycles → back-to-back conversions every 9 cycles.
- Assert rst at the 4th SHIFT cycle of 12'h199 → immediately ready=1, valid=0, bin=0, err=0, and no valid pulse follows. A new conversion of 12'h007 then gives bin=7.

Source files
------------

// File: rtl/bcd2bin_seq_pkg.sv
// Shared constants and state encoding for the sequential BCD-to-binary converter.
package bcd2bin_seq_pkg;

   localparam int DIGIT_W    = 4;
   localparam int DIGIT_MAX  = 9;
   localparam int ADJ_THRESH = 8;
   localparam int ADJ_CONST  = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of reverse double-dabble: subtract 3 when >= 8.
module bcd_digit_adj
   import bcd2bin_seq_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [DIGIT_W-1:0] digit_o
);

   always_comb begin
      digit_o = digit_i;
      if (digit_i >= DIGIT_W'(ADJ_THRESH)) begin
         digit_o = digit_i - DIGIT_W'(ADJ_CONST);
      end
   end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter, one result bit per clock.
// Flags non-decimal digits and values that do not fit in BIN_W bits.
module bcd2bin_seq
   import bcd2bin_seq_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [DIGIT_W*DIGITS-1:0] bcd,
   output logic                      ready,
   output logic                      valid,
   output logic [BIN_W-1:0]          bin,
   output logic                      err,
   output logic [1:0]                dbg_state
);

   // Handshake: start/bcd are taken on a rising edge only while ready=1;
   // valid is a one-cycle pulse and bin/err stay put until the next result.

   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam int SR_W  = BCD_W + BIN_W;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SR_W-1:0]    sr_q, sr_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic               err_q, err_d;

   logic [SR_W-1:0]    sr_shift;
   logic [SR_W-1:0]    sr_adj;
   logic [BCD_W-1:0]   residual;
   logic [DIGITS-1:0]  bad_digit;

   assign sr_shift = sr_q >> 1;
   assign sr_adj[BIN_W-1:0] = sr_shift[BIN_W-1:0];

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_adj u_adj (
         .digit_i (sr_shift[BIN_W + g*DIGIT_W +: DIGIT_W]),
         .digit_o (sr_adj[BIN_W + g*DIGIT_W +: DIGIT_W])
      );
      assign bad_digit[g] = (bcd[g*DIGIT_W +: DIGIT_W] > DIGIT_W'(DIGIT_MAX));
   end

   // After the last shift the BCD field holds floor(value / 2^BIN_W).
   assign residual = sr_adj[SR_W-1:BIN_W];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      bin_d   = bin_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (|bad_digit) begin
                  state_d = ST_DONE;
                  bin_d   = '0;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_SHIFT;
                  sr_d    = {bcd, {BIN_W{1'b0}}};
                  cnt_d   = '0;
               end
            end
         end
         ST_SHIFT: begin
            sr_d  = sr_adj;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               state_d = ST_DONE;
               err_d   = |residual;
               bin_d   = (|residual) ? '0 : sr_adj[BIN_W-1:0];
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         bin_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         bin_q   <= bin_d;
         err_q   <= err_d;
      end
   end

   assign ready     = (state_q == ST_IDLE);
   assign valid     = (state_q == ST_DONE);
   assign bin       = bin_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule
